// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with arbitrary width and depth.
// Any depth >= 2 is supported, including depths that are not a power of two.
// Provides an occupancy count, almost-full/almost-empty thresholds and
// sticky overflow/underflow flags.
// The read side runs either registered (fwft=0) or first-word-fall-through (fwft=1).
module fifo_sync_param #(
    parameter int dato_width      = 8,
    parameter int fifo_length     = 5,
    parameter int almost_full_th  = fifo_length - 1,
    parameter int almost_empty_th = 1,
    parameter bit fwft            = 1'b0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr,
    input  logic [dato_width-1:0]              datin,
    input  logic                               rd,
    input  logic                               clr_err,
    output logic [dato_width-1:0]              datout,
    output logic                               dato,
    output logic                               full,
    output logic                               empy,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic [$clog2(fifo_length+1)-1:0]   count,
    output logic                               overflow,
    output logic                               underflow
);
    localparam int PW = $clog2(fifo_length);
    localparam int CW = $clog2(fifo_length + 1);
    localparam logic [PW-1:0] LAST  = PW'(fifo_length - 1);
    localparam logic [CW-1:0] DEPTH = CW'(fifo_length);
    localparam logic [CW-1:0] AF_TH = CW'(almost_full_th);
    localparam logic [CW-1:0] AE_TH = CW'(almost_empty_th);

    logic [dato_width-1:0] r_mem [fifo_length];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_ovf;
    logic                  r_unf;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    // Explicit wrap so that non-power-of-two depths never index past the array.
    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Full/empty come from the registered count, so requests are judged on pre-edge state.
    always_comb begin
        w_full   = (r_count == DEPTH);
        w_empty  = (r_count == '0);
        w_wr_acc = wr && !w_full;
        w_rd_acc = rd && !w_empty;
    end

    // Storage write; contents are intentionally left untouched by reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst)
            r_mem[r_wr_ptr] <= datin;
    end

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= f_inc(r_wr_ptr);
            if (w_rd_acc)
                r_rd_ptr <= f_inc(r_rd_ptr);
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A new error on the same edge as clr_err wins.
            r_ovf <= (r_ovf && !clr_err) || (wr && w_full);
            r_unf <= (r_unf && !clr_err) || (rd && w_empty);
        end
    end

    // Status decode from the registered count.
    always_comb begin
        full         = w_full;
        empy         = w_empty;
        almost_full  = (r_count >= AF_TH);
        almost_empty = (r_count <= AE_TH);
        count        = r_count;
        overflow     = r_ovf;
        underflow    = r_unf;
    end

    generate
        if (fwft == 1'b0) begin : g_reg
            logic [dato_width-1:0] r_datout;
            logic                  r_dato;
            // Registered read: capture the popped word and raise dato for one cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_datout <= '0;
                    r_dato   <= 1'b0;
                end else begin
                    r_dato <= w_rd_acc;
                    if (w_rd_acc)
                        r_datout <= r_mem[r_rd_ptr];
                end
            end
            assign datout = r_datout;
            assign dato   = r_dato;
        end else begin : g_fwft
            // Head word is always presented; rd acknowledges it.
            assign datout = r_mem[r_rd_ptr];
            assign dato   = !w_empty;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Testbench for fifo_sync_param: table-driven registered-mode vectors,
// FWFT sequence, and a randomized depth-3 scoreboard run.
module tb_fifo_sync_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT A: width 8, depth 5, registered ----------------
    logic       a_rst = 1'b1, a_wr = 1'b0, a_rd = 1'b0, a_clr = 1'b0;
    logic [7:0] a_din = '0, a_dout;
    logic       a_dato, a_full, a_empy, a_af, a_ae, a_ovf, a_unf;
    logic [2:0] a_cnt;
    fifo_sync_param #(.dato_width(8), .fifo_length(5)) u_a (
        .clk(clk), .rst(a_rst), .wr(a_wr), .datin(a_din), .rd(a_rd), .clr_err(a_clr),
        .datout(a_dout), .dato(a_dato), .full(a_full), .empy(a_empy),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt),
        .overflow(a_ovf), .underflow(a_unf));

    // ---------------- DUT F: width 8, depth 5, FWFT ----------------
    logic       f_rst = 1'b1, f_wr = 1'b0, f_rd = 1'b0, f_clr = 1'b0;
    logic [7:0] f_din = '0, f_dout;
    logic       f_dato, f_full, f_empy, f_af, f_ae, f_ovf, f_unf;
    logic [2:0] f_cnt;
    fifo_sync_param #(.dato_width(8), .fifo_length(5), .fwft(1'b1)) u_f (
        .clk(clk), .rst(f_rst), .wr(f_wr), .datin(f_din), .rd(f_rd), .clr_err(f_clr),
        .datout(f_dout), .dato(f_dato), .full(f_full), .empy(f_empy),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
        .overflow(f_ovf), .underflow(f_unf));

    // ---------------- DUT N: width 12, depth 3, registered ----------------
    logic        n_rst = 1'b1, n_wr = 1'b0, n_rd = 1'b0, n_clr = 1'b0;
    logic [11:0] n_din = '0, n_dout;
    logic        n_dato, n_full, n_empy, n_af, n_ae, n_ovf, n_unf;
    logic [1:0]  n_cnt;
    fifo_sync_param #(.dato_width(12), .fifo_length(3)) u_n (
        .clk(clk), .rst(n_rst), .wr(n_wr), .datin(n_din), .rd(n_rd), .clr_err(n_clr),
        .datout(n_dout), .dato(n_dato), .full(n_full), .empy(n_empy),
        .almost_full(n_af), .almost_empty(n_ae), .count(n_cnt),
        .overflow(n_ovf), .underflow(n_unf));

    typedef struct {
        bit       rst, wr, rd, clr;
        bit [7:0] din;
        int       cnt;
        bit       dato;
        bit [7:0] dout;
        bit       ovf, unf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, wr, rd, clr, input bit [7:0] din,
                       input int cnt, input bit dato, input bit [7:0] dout,
                       input bit ovf, unf);
        vec_t v;
        v.rst = rst; v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
        v.cnt = cnt; v.dato = dato; v.dout = dout; v.ovf = ovf; v.unf = unf;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic fstep(input bit wr, rd, input bit [7:0] din);
        f_wr = wr; f_rd = rd; f_din = din;
        @(posedge clk); #1;
        f_wr = 1'b0; f_rd = 1'b0;
    endtask

    logic [17:0] got_v, exp_v;
    logic [11:0] q[$];
    logic [11:0] exp_d;
    int          mcnt, pushed, cyc;
    bit          acc_w, acc_r;

    initial begin
        // ---- table for DUT A (depth 5, af at >=4, ae at <=1) ----
        // reset with a coincident write
        add(1,1,0,0,8'h99, 0,0,8'h00,0,0);
        // fill 0x11..0x55, then overflow attempt
        add(0,1,0,0,8'h11, 1,0,8'h00,0,0);
        add(0,1,0,0,8'h22, 2,0,8'h00,0,0);
        add(0,1,0,0,8'h33, 3,0,8'h00,0,0);
        add(0,1,0,0,8'h44, 4,0,8'h00,0,0);
        add(0,1,0,0,8'h55, 5,0,8'h00,0,0);
        add(0,1,0,0,8'h66, 5,0,8'h00,1,0);
        // drain, then underflow attempt; datout holds 0x55
        add(0,0,1,0,8'h00, 4,1,8'h11,1,0);
        add(0,0,1,0,8'h00, 3,1,8'h22,1,0);
        add(0,0,1,0,8'h00, 2,1,8'h33,1,0);
        add(0,0,1,0,8'h00, 1,1,8'h44,1,0);
        add(0,0,1,0,8'h00, 0,1,8'h55,1,0);
        add(0,0,1,0,8'h00, 0,0,8'h55,1,1);
        add(0,0,0,1,8'h00, 0,0,8'h55,0,0);
        // interleaved refill: pointers wrap a second time
        add(0,1,0,0,8'hA0, 1,0,8'h55,0,0);
        add(0,1,1,0,8'hA1, 1,1,8'hA0,0,0);
        add(0,1,1,0,8'hA2, 1,1,8'hA1,0,0);
        add(0,1,1,0,8'hA3, 1,1,8'hA2,0,0);
        add(0,1,1,0,8'hA4, 1,1,8'hA3,0,0);
        add(0,1,1,0,8'hA5, 1,1,8'hA4,0,0);
        add(0,1,1,0,8'hA6, 1,1,8'hA5,0,0);
        add(0,0,1,0,8'h00, 0,1,8'hA6,0,0);
        add(0,0,0,0,8'h00, 0,0,8'hA6,0,0);
        // count 3, then 10 cycles of simultaneous wr+rd
        add(0,1,0,0,8'hB0, 1,0,8'hA6,0,0);
        add(0,1,0,0,8'hB1, 2,0,8'hA6,0,0);
        add(0,1,0,0,8'hB2, 3,0,8'hA6,0,0);
        for (int i = 0; i < 10; i++)
            add(0,1,1,0,8'(8'hC0 + i), 3,1, (i < 3) ? 8'(8'hB0 + i) : 8'(8'hC0 + i - 3), 0,0);
        // to full, then wr+rd at full
        add(0,1,0,0,8'hD0, 4,0,8'hC6,0,0);
        add(0,1,0,0,8'hD1, 5,0,8'hC6,0,0);
        add(0,1,1,0,8'hE0, 4,1,8'hC7,1,0);
        add(0,0,1,0,8'h00, 3,1,8'hC8,1,0);
        add(0,0,1,0,8'h00, 2,1,8'hC9,1,0);
        add(0,0,1,0,8'h00, 1,1,8'hD0,1,0);
        add(0,0,1,0,8'h00, 0,1,8'hD1,1,0);
        // wr+rd at empty
        add(0,1,1,0,8'hF0, 1,0,8'hD1,1,1);
        add(0,0,1,0,8'h00, 0,1,8'hF0,1,1);
        // clr_err with a new underflow keeps underflow; overflow clears
        add(0,0,1,1,8'h00, 0,0,8'hF0,0,1);
        add(0,0,0,1,8'h00, 0,0,8'hF0,0,0);
        // reach count 3 with overflow set
        add(0,1,0,0,8'h01, 1,0,8'hF0,0,0);
        add(0,1,0,0,8'h02, 2,0,8'hF0,0,0);
        add(0,1,0,0,8'h03, 3,0,8'hF0,0,0);
        add(0,1,0,0,8'h04, 4,0,8'hF0,0,0);
        add(0,1,0,0,8'h05, 5,0,8'hF0,0,0);
        add(0,1,0,0,8'h06, 5,0,8'hF0,1,0);
        add(0,0,1,0,8'h00, 4,1,8'h01,1,0);
        add(0,0,1,0,8'h00, 3,1,8'h02,1,0);
        // reset together with a write: write discarded
        add(1,1,0,0,8'h77, 0,0,8'h00,0,0);
        add(0,0,0,0,8'h00, 0,0,8'h00,0,0);
        add(0,1,0,0,8'h88, 1,0,8'h00,0,0);
        add(0,0,1,0,8'h00, 0,1,8'h88,0,0);

        foreach (tbl[i]) begin
            a_rst = tbl[i].rst; a_wr = tbl[i].wr; a_rd = tbl[i].rd;
            a_clr = tbl[i].clr; a_din = tbl[i].din;
            @(posedge clk); #1;
            got_v = {a_cnt, a_full, a_empy, a_af, a_ae, a_dato, a_dout, a_ovf, a_unf};
            exp_v = {3'(tbl[i].cnt), tbl[i].cnt == 5, tbl[i].cnt == 0,
                     tbl[i].cnt >= 4, tbl[i].cnt <= 1, tbl[i].dato, tbl[i].dout,
                     tbl[i].ovf, tbl[i].unf};
            chk($sformatf("vec%0d{cnt,f,e,af,ae,v,d,o,u}", i), 32'(got_v), 32'(exp_v));
        end
        a_rst = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0;

        // ---- FWFT sequence ----
        fstep(0, 0, 8'h00);           // edge with rst held
        chk("fwft_rst_empy", 32'(f_empy), 32'd1);
        chk("fwft_rst_dato", 32'(f_dato), 32'd0);
        f_rst = 1'b0;
        fstep(1, 0, 8'h3C);
        chk("fwft_wr_dout", 32'(f_dout), 32'h3C);
        chk("fwft_wr_dato", 32'(f_dato), 32'd1);
        chk("fwft_wr_cnt", 32'(f_cnt), 32'd1);
        fstep(0, 1, 8'h00);
        chk("fwft_rd_empy", 32'(f_empy), 32'd1);
        chk("fwft_rd_dato", 32'(f_dato), 32'd0);
        fstep(1, 0, 8'h5A);
        fstep(1, 0, 8'h6B);
        chk("fwft_head", 32'(f_dout), 32'h5A);
        fstep(1, 1, 8'h7C);
        chk("fwft_pop1", 32'(f_dout), 32'h6B);
        chk("fwft_cnt2", 32'(f_cnt), 32'd2);
        fstep(0, 1, 8'h00);
        chk("fwft_pop2", 32'(f_dout), 32'h7C);
        fstep(0, 1, 8'h00);
        chk("fwft_drain_dato", 32'(f_dato), 32'd0);

        // ---- depth 3, width 12 random scoreboard ----
        @(posedge clk); #1;
        n_rst = 1'b0;
        chk("n_rst_cnt", 32'(n_cnt), 32'd0);
        mcnt = 0; pushed = 0; cyc = 0;
        while ((pushed < 100 || q.size() > 0) && cyc < 3000) begin
            n_wr  = (pushed < 100) && ($urandom_range(0, 9) < 6);
            n_rd  = ($urandom_range(0, 9) < 5);
            n_din = 12'($urandom);
            acc_w = n_wr && (mcnt < 3);
            acc_r = n_rd && (mcnt > 0);
            if (acc_r) exp_d = q.pop_front();
            if (acc_w) begin q.push_back(n_din); pushed++; end
            mcnt = mcnt + int'(acc_w) - int'(acc_r);
            @(posedge clk); #1;
            cyc++;
            chk("n_cnt", 32'(n_cnt), 32'(mcnt));
            chk("n_cnt_le3", 32'(n_cnt > 2'd3), 32'd0);
            chk("n_dato", 32'(n_dato), 32'(acc_r));
            if (acc_r) chk("n_dout", 32'(n_dout), 32'(exp_d));
        end
        n_wr = 1'b0; n_rd = 1'b0;
        chk("n_all_words_through", 32'(pushed == 100 && q.size() == 0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
